// File: rtl/xpb_lut_seq_if.sv
// Load and lookup signal bundle for xpb_lut_seq.
// The slave modport is the table side; the master modport is the load and lookup side.
interface xpb_lut_seq_if #(
  parameter int unsigned IDX_BITS  = 5,
  parameter int unsigned WORD_BITS = 1024,
  parameter int unsigned SEG_BITS  = 64,
  parameter int unsigned NUM_CH    = 4
);
  logic                          ld_start;
  logic                          ld_valid;
  logic                          ld_ready;
  logic [SEG_BITS-1:0]           ld_data;
  logic                          table_ok;
  logic [NUM_CH-1:0]             lk_valid;
  logic [NUM_CH*IDX_BITS-1:0]    lk_idx;
  logic [NUM_CH-1:0]             lk_out_valid;
  logic [NUM_CH*WORD_BITS-1:0]   lk_out_data;
  logic [NUM_CH-1:0]             lk_err;

  modport master (
    output ld_start, ld_valid, ld_data, lk_valid, lk_idx,
    input  ld_ready, table_ok, lk_out_valid, lk_out_data, lk_err
  );

  modport slave (
    input  ld_start, ld_valid, ld_data, lk_valid, lk_idx,
    output ld_ready, table_ok, lk_out_valid, lk_out_data, lk_err
  );
endinterface

// File: rtl/xpb_lut_seq.sv
// Loadable multi-channel XPB lookup table: entries streamed in as segments, read by NUM_CH ports.
// Define XPB_LUT_OUT_PIPE_EN to add a second output register stage (lookup latency 2).
module xpb_lut_seq #(
  parameter int unsigned IDX_BITS  = 5,
  parameter int unsigned WORD_BITS = 1024,
  parameter int unsigned SEG_BITS  = 64,
  parameter int unsigned NUM_CH    = 4
) (
  input logic          clk,
  input logic          rst_n,
  xpb_lut_seq_if.slave bus
);
  localparam int unsigned SEGS  = WORD_BITS / SEG_BITS;
  localparam int unsigned SEG_W = (SEGS > 1) ? $clog2(SEGS) : 1;
  localparam int unsigned DEPTH = 1 << IDX_BITS;

  localparam logic [1:0] StEmpty = 2'd0;
  localparam logic [1:0] StLoad  = 2'd1;
  localparam logic [1:0] StFull  = 2'd2;

  logic [1:0]          state_q, state_d;
  logic [SEG_W-1:0]    seg_q, seg_d;
  logic [IDX_BITS-1:0] ent_q, ent_d;
  logic                ld_ready, table_ok, ld_fire, seg_last, ent_last;

  logic [WORD_BITS-1:0] mem [DEPTH];

  assign ld_ready     = (state_q == StLoad) && !bus.ld_start;
  assign table_ok     = (state_q == StFull);
  assign ld_fire      = bus.ld_valid && ld_ready;
  assign seg_last     = (seg_q == SEG_W'(SEGS - 1));
  assign ent_last     = &ent_q;
  assign bus.ld_ready = ld_ready;
  assign bus.table_ok = table_ok;

  always_comb begin
    state_d = state_q;
    seg_d   = seg_q;
    ent_d   = ent_q;
    unique case (state_q)
      StEmpty, StFull: begin
        if (bus.ld_start) begin
          state_d = StLoad;
          seg_d   = '0;
          ent_d   = '0;
        end
      end
      StLoad: begin
        if (bus.ld_start) begin
          seg_d = '0;
          ent_d = '0;
        end else if (ld_fire) begin
          if (seg_last) begin
            seg_d = '0;
            // Entry counter rolls over to 0 exactly when the final beat lands.
            ent_d = ent_q + IDX_BITS'(1);
            if (ent_last) state_d = StFull;
          end else begin
            seg_d = seg_q + SEG_W'(1);
          end
        end
      end
      default: state_d = StEmpty;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StEmpty;
      seg_q   <= '0;
      ent_q   <= '0;
    end else begin
      state_q <= state_d;
      seg_q   <= seg_d;
      ent_q   <= ent_d;
    end
  end

  // Table storage is deliberately not reset; stale words survive a reload until overwritten.
  always_ff @(posedge clk) begin
    if (ld_fire) mem[ent_q][seg_q*SEG_BITS +: SEG_BITS] <= bus.ld_data;
  end

  logic [NUM_CH-1:0]    vld_q, err_q;
  logic [WORD_BITS-1:0] dat_q [NUM_CH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      err_q <= '0;
      for (int c = 0; c < NUM_CH; c++) dat_q[c] <= '0;
    end else begin
      vld_q <= bus.lk_valid;
      err_q <= bus.lk_valid & {NUM_CH{!table_ok}};
      for (int c = 0; c < NUM_CH; c++) begin
        if (bus.lk_valid[c]) begin
          dat_q[c] <= table_ok ? mem[bus.lk_idx[c*IDX_BITS +: IDX_BITS]] : '0;
        end
      end
    end
  end

`ifdef XPB_LUT_OUT_PIPE_EN
  logic [NUM_CH-1:0]    vld2_q, err2_q;
  logic [WORD_BITS-1:0] dat2_q [NUM_CH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld2_q <= '0;
      err2_q <= '0;
      for (int c = 0; c < NUM_CH; c++) dat2_q[c] <= '0;
    end else begin
      vld2_q <= vld_q;
      err2_q <= err_q;
      for (int c = 0; c < NUM_CH; c++) dat2_q[c] <= dat_q[c];
    end
  end

  always_comb begin
    bus.lk_out_valid = vld2_q;
    bus.lk_err       = err2_q;
    bus.lk_out_data  = '0;
    for (int c = 0; c < NUM_CH; c++) bus.lk_out_data[c*WORD_BITS +: WORD_BITS] = dat2_q[c];
  end
`else
  always_comb begin
    bus.lk_out_valid = vld_q;
    bus.lk_err       = err_q;
    bus.lk_out_data  = '0;
    for (int c = 0; c < NUM_CH; c++) bus.lk_out_data[c*WORD_BITS +: WORD_BITS] = dat_q[c];
  end
`endif

endmodule

// File: tb/tb_xpb_lut_seq.sv
// Self-checking bench for xpb_lut_seq against a table model built from the load stream.
// Honours XPB_LUT_OUT_PIPE_EN for the expected lookup latency.
`timescale 1ns/1ps
module tb_xpb_lut_seq;
  localparam int unsigned IDX_BITS  = 5;
  localparam int unsigned WORD_BITS = 1024;
  localparam int unsigned SEG_BITS  = 64;
  localparam int unsigned NUM_CH    = 4;
  localparam int unsigned SEGS      = WORD_BITS / SEG_BITS;
  localparam int unsigned DEPTH     = 1 << IDX_BITS;
  localparam int unsigned BEATS     = SEGS * DEPTH;
  localparam int unsigned B2B_N     = 40;
`ifdef XPB_LUT_OUT_PIPE_EN
  localparam int unsigned LAT = 2;
`else
  localparam int unsigned LAT = 1;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  xpb_lut_seq_if #(.IDX_BITS(IDX_BITS), .WORD_BITS(WORD_BITS), .SEG_BITS(SEG_BITS),
                   .NUM_CH(NUM_CH)) bus ();

  xpb_lut_seq #(.IDX_BITS(IDX_BITS), .WORD_BITS(WORD_BITS), .SEG_BITS(SEG_BITS),
                .NUM_CH(NUM_CH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  // Reference: the table as a plain array filled beat by beat, plus a loaded flag.
  logic [WORD_BITS-1:0] mdl_mem [DEPTH];
  bit                   mdl_ok;
  int                   mdl_beat;
  int                   total;
  int                   bad;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.ld_start = 1'b0;
    bus.ld_valid = 1'b0;
    bus.ld_data  = '0;
    bus.lk_valid = '0;
    bus.lk_idx   = '0;
  endtask

  task automatic feed(input logic [SEG_BITS-1:0] d);
    bus.ld_valid = 1'b1;
    bus.ld_data  = d;
    tick();
    mdl_mem[mdl_beat / SEGS][(mdl_beat % SEGS)*SEG_BITS +: SEG_BITS] = d;
    mdl_beat++;
    if (mdl_beat == BEATS) begin
      mdl_ok   = 1'b1;
      mdl_beat = 0;
    end
    bus.ld_valid = 1'b0;
  endtask

  task automatic start_load();
    bus.ld_start = 1'b1;
    bus.ld_valid = 1'b0;
    tick();
    bus.ld_start = 1'b0;
    mdl_ok   = 1'b0;
    mdl_beat = 0;
  endtask

  task automatic test_reset();
    logic [NUM_CH*WORD_BITS-1:0] od;
    idle_inputs();
    rst_n = 1'b0;
    #1;
    od = bus.lk_out_data;
    total++;
    if (bus.ld_ready !== 1'b0 || bus.table_ok !== 1'b0) begin
      bad++;
      $display("FAIL reset_ctrl: got ready=%b ok=%b want 0 0", bus.ld_ready, bus.table_ok);
    end
    total++;
    if (bus.lk_out_valid !== '0 || bus.lk_err !== '0 || od !== '0) begin
      bad++;
      $display("FAIL reset_out: got v=%b e=%b d=%h want 0 0 0", bus.lk_out_valid, bus.lk_err,
               od[127:0]);
    end
    tick();
    rst_n = 1'b1;
    tick();
    bus.lk_valid = '1;
    bus.lk_idx   = '0;
    tick();
    bus.lk_valid = '0;
    repeat (LAT - 1) tick();
    od = bus.lk_out_data;
    total++;
    if (bus.lk_out_valid !== 4'hF || bus.lk_err !== 4'hF || od !== '0) begin
      bad++;
      $display("FAIL empty_lookup: got v=%h e=%h d=%h want F F 0", bus.lk_out_valid, bus.lk_err,
               od[127:0]);
    end
    total++;
    if (bus.ld_ready !== 1'b0 || bus.table_ok !== 1'b0) begin
      bad++;
      $display("FAIL empty_ctrl: got ready=%b ok=%b want 0 0", bus.ld_ready, bus.table_ok);
    end
    tick();
  endtask

  task automatic test_pattern_load();
    logic [WORD_BITS-1:0] w;
    start_load();
    total++;
    if (bus.table_ok !== 1'b0) begin
      bad++;
      $display("FAIL load_start_ok: got %b want 0", bus.table_ok);
    end
    for (int n = 0; n < BEATS; n++) begin
      bus.ld_valid = 1'b1;
      bus.ld_data  = {32'h0, 32'(n)};
      if (n == BEATS - 1) begin
        bus.lk_valid = 4'b0001;
        bus.lk_idx   = 20'($urandom);
      end
      #1;
      total++;
      if (bus.ld_ready !== 1'b1 || bus.table_ok !== 1'b0) begin
        bad++;
        $display("FAIL load_hs beat %0d: got ready=%b ok=%b want 1 0", n, bus.ld_ready,
                 bus.table_ok);
      end
      feed({32'h0, 32'(n)});
    end
    bus.lk_valid = '0;
    total++;
    if (bus.table_ok !== 1'b1) begin
      bad++;
      $display("FAIL ok_after_last: got %b want 1", bus.table_ok);
    end
    repeat (LAT - 1) tick();
    w = bus.lk_out_data[WORD_BITS-1:0];
    total++;
    if (bus.lk_out_valid[0] !== 1'b1 || bus.lk_err[0] !== 1'b1 || w !== '0) begin
      bad++;
      $display("FAIL last_beat_lookup: got v=%b e=%b d=%h want 1 1 0", bus.lk_out_valid[0],
               bus.lk_err[0], w[127:0]);
    end
    bus.lk_valid = 4'b0001;
    bus.lk_idx   = 20'd3;
    tick();
    bus.lk_valid = '0;
    repeat (LAT - 1) tick();
    w = bus.lk_out_data[WORD_BITS-1:0];
    total++;
    if (w[63:0] !== 64'd48 || w[1023:960] !== 64'd63 || bus.lk_err[0] !== 1'b0) begin
      bad++;
      $display("FAIL idx3_segs: got ls=%0d ms=%0d e=%b want 48 63 0", w[63:0], w[1023:960],
               bus.lk_err[0]);
    end
    total++;
    if (w !== mdl_mem[3]) begin
      bad++;
      $display("FAIL idx3_word: got %h want %h", w[127:0], mdl_mem[3][127:0]);
    end
    repeat (2) tick();
  endtask

  task automatic test_multi_channel();
    logic [IDX_BITS-1:0]         idx [NUM_CH];
    logic [NUM_CH*WORD_BITS-1:0] od;
    logic [WORD_BITS-1:0]        g;
    idx = '{5'd0, 5'd7, 5'd7, 5'd31};
    bus.lk_valid = '1;
    for (int c = 0; c < NUM_CH; c++) bus.lk_idx[c*IDX_BITS +: IDX_BITS] = idx[c];
    tick();
    bus.lk_valid = '0;
`ifdef XPB_LUT_OUT_PIPE_EN
    total++;
    if (bus.lk_out_valid !== '0) begin
      bad++;
      $display("FAIL pipe_early: got v=%b want 0 one cycle after request", bus.lk_out_valid);
    end
    tick();
`endif
    od = bus.lk_out_data;
    total++;
    if (bus.lk_out_valid !== 4'hF || bus.lk_err !== 4'h0) begin
      bad++;
      $display("FAIL multi_flags: got v=%h e=%h want F 0", bus.lk_out_valid, bus.lk_err);
    end
    for (int c = 0; c < NUM_CH; c++) begin
      g = od[c*WORD_BITS +: WORD_BITS];
      total++;
      if (g !== mdl_mem[idx[c]]) begin
        bad++;
        $display("FAIL multi_data ch%0d: got %h want %h", c, g[127:0], mdl_mem[idx[c]][127:0]);
      end
    end
    g = od[3*WORD_BITS +: WORD_BITS];
    total++;
    if (g[63:0] !== 64'd496) begin
      bad++;
      $display("FAIL ch3_ls_seg: got %0d want 496", g[63:0]);
    end
    tick();
  endtask

  task automatic test_restart();
    logic [SEG_BITS-1:0] d;
    total++;
    if (bus.table_ok !== 1'b1) begin
      bad++;
      $display("FAIL full_before_restart: got %b want 1", bus.table_ok);
    end
    start_load();
    total++;
    if (bus.table_ok !== 1'b0) begin
      bad++;
      $display("FAIL ok_drop: got %b want 0", bus.table_ok);
    end
    for (int n = 0; n < 100; n++) feed({$urandom, $urandom});
    bus.ld_start = 1'b1;
    bus.ld_valid = 1'b1;
    bus.ld_data  = {$urandom, $urandom};
    #1;
    total++;
    if (bus.ld_ready !== 1'b0) begin
      bad++;
      $display("FAIL start_cycle_ready: got %b want 0", bus.ld_ready);
    end
    tick();
    bus.ld_start = 1'b0;
    mdl_ok   = 1'b0;
    mdl_beat = 0;
    for (int n = 0; n < BEATS; n++) begin
      d = {$urandom, $urandom};
      bus.ld_valid = 1'b1;
      bus.ld_data  = d;
      #1;
      total++;
      if (bus.ld_ready !== 1'b1 || bus.table_ok !== 1'b0) begin
        bad++;
        $display("FAIL reload_hs beat %0d: got ready=%b ok=%b want 1 0", n, bus.ld_ready,
                 bus.table_ok);
      end
      feed(d);
    end
    total++;
    if (bus.table_ok !== 1'b1) begin
      bad++;
      $display("FAIL reload_done: got %b want 1", bus.table_ok);
    end
  endtask

  task automatic test_back_to_back(input string tag);
    logic [NUM_CH-1:0]           ev [B2B_N];
    logic [NUM_CH-1:0]           ee [B2B_N];
    logic [WORD_BITS-1:0]        ed [B2B_N][NUM_CH];
    logic [WORD_BITS-1:0]        last [NUM_CH];
    logic [NUM_CH-1:0]           v;
    logic [IDX_BITS-1:0]         ix;
    logic [NUM_CH*WORD_BITS-1:0] od;
    logic [WORD_BITS-1:0]        g;
    int                          j;
    for (int c = 0; c < NUM_CH; c++) last[c] = '0;
    for (int i = 0; i < int'(B2B_N + LAT - 1); i++) begin
      if (i < int'(B2B_N)) begin
        v = (i == 0) ? '1 : NUM_CH'($urandom);
        for (int c = 0; c < NUM_CH; c++) begin
          ix = ($urandom_range(0, 3) == 0) ? IDX_BITS'(7) : IDX_BITS'($urandom);
          bus.lk_idx[c*IDX_BITS +: IDX_BITS] = ix;
          ee[i][c] = v[c] && !mdl_ok;
          if (v[c]) last[c] = mdl_ok ? mdl_mem[ix] : '0;
          ed[i][c] = last[c];
        end
        ev[i] = v;
        bus.lk_valid = v;
      end else begin
        bus.lk_valid = '0;
      end
      tick();
      j = i - int'(LAT) + 1;
      if (j >= 0) begin
        od = bus.lk_out_data;
        total++;
        if (bus.lk_out_valid !== ev[j] || bus.lk_err !== ee[j]) begin
          bad++;
          $display("FAIL %s flags[%0d]: got v=%b e=%b want v=%b e=%b", tag, j,
                   bus.lk_out_valid, bus.lk_err, ev[j], ee[j]);
        end
        for (int c = 0; c < NUM_CH; c++) begin
          g = od[c*WORD_BITS +: WORD_BITS];
          total++;
          if (g !== ed[j][c]) begin
            bad++;
            $display("FAIL %s data[%0d] ch%0d: got %h want %h", tag, j, c, g[127:0],
                     ed[j][c][127:0]);
          end
        end
      end
    end
    bus.lk_valid = '0;
    tick();
  endtask

  task automatic test_reset_mid_load();
    logic [NUM_CH*WORD_BITS-1:0] od;
    start_load();
    for (int n = 0; n < 199; n++) begin
      bus.lk_valid = (n >= 196) ? '1 : '0;
      feed({$urandom, $urandom});
    end
    bus.lk_valid = '0;
    total++;
    if (bus.lk_out_valid !== 4'hF || bus.lk_err !== 4'hF) begin
      bad++;
      $display("FAIL load_lookup_err: got v=%h e=%h want F F", bus.lk_out_valid, bus.lk_err);
    end
    bus.ld_valid = 1'b1;
    bus.ld_data  = {$urandom, $urandom};
    #1;
    rst_n = 1'b0;
    #1;
    od = bus.lk_out_data;
    total++;
    if (bus.ld_ready !== 1'b0 || bus.table_ok !== 1'b0) begin
      bad++;
      $display("FAIL midrst_ctrl: got ready=%b ok=%b want 0 0", bus.ld_ready, bus.table_ok);
    end
    total++;
    if (bus.lk_out_valid !== '0 || bus.lk_err !== '0 || od !== '0) begin
      bad++;
      $display("FAIL midrst_out: got v=%b e=%b d=%h want 0 0 0", bus.lk_out_valid, bus.lk_err,
               od[127:0]);
    end
    tick();
    rst_n = 1'b1;
    mdl_ok   = 1'b0;
    mdl_beat = 0;
    tick();
    total++;
    if (bus.ld_ready !== 1'b0 || bus.table_ok !== 1'b0) begin
      bad++;
      $display("FAIL post_rst_empty: got ready=%b ok=%b want 0 0", bus.ld_ready, bus.table_ok);
    end
    bus.ld_valid = 1'b0;
  endtask

  task automatic test_final_load();
    start_load();
    for (int n = 0; n < BEATS; n++) feed({$urandom, $urandom});
    total++;
    if (bus.table_ok !== 1'b1) begin
      bad++;
      $display("FAIL final_load_ok: got %b want 1", bus.table_ok);
    end
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    mdl_ok   = 1'b0;
    mdl_beat = 0;
    for (int i = 0; i < int'(DEPTH); i++) mdl_mem[i] = '0;
    test_reset();
    test_pattern_load();
    test_multi_channel();
    test_restart();
    test_back_to_back("full");
    test_reset_mid_load();
    test_back_to_back("empty");
    test_final_load();
    test_back_to_back("reload");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
